// File: rtl/icache_tag_ctrl_if.sv
// Bundles the lookup, fill, flush and tag-RAM signals of the I-cache tag controller.
interface icache_tag_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned OFS_W  = 4
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFS_W;

  // Lookup request and response
  logic              lk_req;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_ready;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [IDX_W-1:0]  rsp_idx;

  // Line-fill tag write request
  logic              fill_valid;
  logic [ADDR_W-1:0] fill_addr;
  logic              fill_ready;

  // Invalidate-all control
  logic              flush_req;
  logic              flush_busy;
  logic              flush_done;

  // Tag RAM ports
  logic              tag_wr_en;
  logic [IDX_W-1:0]  tag_wr_addr;
  logic [TAG_W:0]    tag_wr_data;
  logic [IDX_W-1:0]  tag_rd_addr;
  logic [TAG_W:0]    tag_rd_data;

  // Controller side
  modport slave (
    input  lk_req, lk_addr, fill_valid, fill_addr, flush_req, tag_rd_data,
    output lk_ready, rsp_valid, rsp_hit, rsp_idx, fill_ready,
           flush_busy, flush_done, tag_wr_en, tag_wr_addr, tag_wr_data, tag_rd_addr
  );

  // Fetch / refill / RAM side
  modport master (
    output lk_req, lk_addr, fill_valid, fill_addr, flush_req, tag_rd_data,
    input  lk_ready, rsp_valid, rsp_hit, rsp_idx, fill_ready,
           flush_busy, flush_done, tag_wr_en, tag_wr_addr, tag_wr_data, tag_rd_addr
  );
endinterface

// File: rtl/icache_tag_ctrl.sv
// I-cache tag RAM sequencer: invalidation sweep, line-fill tag writes and
// pipelined tag lookups with read-during-write bypass.
module icache_tag_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned OFS_W  = 4
) (
  input logic              clk,
  input logic              rst,
  icache_tag_ctrl_if.slave bus
);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - OFS_W;
  localparam int unsigned ENT_W = TAG_W + 1;

  localparam logic [0:0] SWEEP = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = '1;

  // FSM and sweep counter
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             done_q;

  // Lookup pipeline stage
  logic             rsp_valid_q;
  logic [IDX_W-1:0] rsp_idx_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             byp_q;
  logic [ENT_W-1:0] byp_data_q;
  logic [IDX_W-1:0] rd_addr_q;

  // Combinational decode
  logic [IDX_W-1:0] lk_idx_c, fill_idx_c;
  logic [TAG_W-1:0] lk_tag_c, fill_tag_c;
  logic             run_c, sweep_c, lk_acc_c, fill_acc_c;
  logic             wr_en_c;
  logic [IDX_W-1:0] wr_addr_c;
  logic [ENT_W-1:0] wr_data_c;
  logic [ENT_W-1:0] entry_c;
  logic             rsp_valid_c;
  logic             unused_ofs;

  // Address split into index and tag fields
  assign lk_idx_c   = bus.lk_addr[OFS_W+IDX_W-1:OFS_W];
  assign lk_tag_c   = bus.lk_addr[ADDR_W-1:OFS_W+IDX_W];
  assign fill_idx_c = bus.fill_addr[OFS_W+IDX_W-1:OFS_W];
  assign fill_tag_c = bus.fill_addr[ADDR_W-1:OFS_W+IDX_W];
  assign unused_ofs = ^{bus.lk_addr[OFS_W-1:0], bus.fill_addr[OFS_W-1:0]};

  // Handshake qualification; reset blocks all acceptance
  assign run_c      = (state_q == RUN) && !rst;
  assign sweep_c    = (state_q == SWEEP) && !rst;
  assign lk_acc_c   = run_c && bus.lk_req;
  assign fill_acc_c = run_c && !bus.flush_req && bus.fill_valid;

  // Next-state logic and tag write-port mux
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_c   = 1'b0;
    wr_addr_c = cnt_q;
    wr_data_c = '0;
    case (state_q)
      SWEEP: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = SWEEP;
        cnt_d   = '0;
      end
    endcase
    if (sweep_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = cnt_q;
      wr_data_c = '0;
    end else if (fill_acc_c) begin
      wr_en_c   = 1'b1;
      wr_addr_c = fill_idx_c;
      wr_data_c = {1'b1, fill_tag_c};
    end
  end

  // State, counter and response-control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SWEEP;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      byp_q       <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= (state_q == SWEEP) && (cnt_q == LAST_IDX);
      rsp_valid_q <= lk_acc_c;
      if (lk_acc_c) begin
        rsp_idx_q <= lk_idx_c;
        rd_addr_q <= lk_idx_c;
        // RAM read-during-write is undefined, so remember the colliding write
        byp_q     <= wr_en_c && (wr_addr_c == lk_idx_c);
      end
    end
  end

  // Lookup datapath registers, qualified by rsp_valid_q and byp_q
  always_ff @(posedge clk) begin
    if (lk_acc_c) begin
      rsp_tag_q  <= lk_tag_c;
      byp_data_q <= wr_data_c;
    end
  end

  // Select bypassed write data over the RAM output on a same-index collision
  always_comb begin
    entry_c = bus.tag_rd_data;
    if (byp_q) begin
      entry_c = byp_data_q;
    end
  end

  assign rsp_valid_c = rsp_valid_q && !rst;

  assign bus.lk_ready    = run_c;
  assign bus.fill_ready  = run_c && !bus.flush_req;
  assign bus.flush_busy  = rst || (state_q == SWEEP);
  assign bus.flush_done  = done_q && !rst;
  assign bus.rsp_valid   = rsp_valid_c;
  assign bus.rsp_idx     = rst ? '0 : rsp_idx_q;
  assign bus.rsp_hit     = rsp_valid_c && entry_c[TAG_W] && (entry_c[TAG_W-1:0] == rsp_tag_q);
  assign bus.tag_wr_en   = wr_en_c;
  assign bus.tag_wr_addr = wr_addr_c;
  assign bus.tag_wr_data = wr_data_c;
  assign bus.tag_rd_addr = lk_acc_c ? lk_idx_c : rd_addr_q;

endmodule
